// File: rtl/abr_ram_rd_stream_if.sv
// Valid/ready word stream carried from the RAM read sequencer to the datapath.
interface abr_ram_rd_stream_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/abr_ram_rd_stream.sv
// Burst read sequencer: drives a 1-cycle-latency RAM read port and streams words out via a 2-entry buffer.
// Optional feature macro: ABR_RD_STREAM_ABORT_EN (adds abort_i to cancel a burst in flight).
module abr_ram_rd_stream #(
   parameter int DEPTH      = 64,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [LEN_WIDTH-1:0]  len_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  ram_re_o,
   output logic [ADDR_WIDTH-1:0] ram_raddr_o,
   input  logic [DATA_WIDTH-1:0] ram_rdata_i,
`ifdef ABR_RD_STREAM_ABORT_EN
   input  logic                  abort_i,
`endif
   abr_ram_rd_stream_if.master   strm
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q;
   logic [LEN_WIDTH-1:0]  issue_cnt_q, accept_cnt_q;
   logic                  pend_q;
   logic [DATA_WIDTH-1:0] buf_q [2];
   logic                  head_q, tail_q;
   logic [1:0]            count_q;
   logic                  pop, last_pop, abort, credit_ok;
   logic [2:0]            inflight;

`ifdef ABR_RD_STREAM_ABORT_EN
   assign abort = abort_i && (state_q != IDLE);
`else
   assign abort = 1'b0;
`endif

   assign strm.valid  = (count_q != 2'd0);
   assign strm.data   = buf_q[head_q];
   assign ram_raddr_o = rd_ptr_q;

   assign pop      = strm.valid && strm.ready;
   assign last_pop = pop && (accept_cnt_q == LEN_WIDTH'(1));

   // Buffered words plus the read in flight must fit in the buffer after this cycle's pop.
   assign inflight  = {1'b0, count_q} + {2'b00, pend_q};
   assign credit_ok = inflight < (3'd2 + {2'b00, pop});

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = (len_i == '0) ? DONE : RUN;
         RUN:     if (last_pop) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   always_comb begin
      busy_o   = (state_q != IDLE);
      done_o   = (state_q == DONE);
      ram_re_o = (state_q == RUN) && (issue_cnt_q != '0) && credit_ok && !abort;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_q     <= '0;
         issue_cnt_q  <= '0;
         accept_cnt_q <= '0;
         pend_q       <= 1'b0;
         buf_q[0]     <= '0;
         buf_q[1]     <= '0;
         head_q       <= 1'b0;
         tail_q       <= 1'b0;
         count_q      <= 2'd0;
      end else if (abort) begin
         // Drop everything in flight; the stale RAM response next cycle is ignored since pend is cleared.
         issue_cnt_q  <= '0;
         accept_cnt_q <= '0;
         pend_q       <= 1'b0;
         head_q       <= 1'b0;
         tail_q       <= 1'b0;
         count_q      <= 2'd0;
      end else begin
         if (state_q == IDLE && start_i) begin
            rd_ptr_q     <= base_addr_i;
            issue_cnt_q  <= len_i;
            accept_cnt_q <= len_i;
         end
         if (ram_re_o) begin
            rd_ptr_q    <= (rd_ptr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            issue_cnt_q <= issue_cnt_q - 1'b1;
         end
         pend_q <= ram_re_o;
         if (pend_q) begin
            buf_q[tail_q] <= ram_rdata_i;
            tail_q        <= ~tail_q;
         end
         if (pop) begin
            head_q       <= ~head_q;
            accept_cnt_q <= accept_cnt_q - 1'b1;
         end
         count_q <= count_q + {1'b0, pend_q} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_abr_ram_rd_stream.sv
// Bench for abr_ram_rd_stream: burst-level scoreboard checked every cycle plus directed literal checks.
module tb_abr_ram_rd_stream;
   localparam int DEPTH = 64;
   localparam int DW    = 32;
   localparam int AW    = 6;
   localparam int LW    = 7;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base = '0;
   logic [LW-1:0] len = '0;
   logic          busy, done, re;
   logic [AW-1:0] raddr;
   logic [DW-1:0] rdata = '0;
`ifdef ABR_RD_STREAM_ABORT_EN
   logic          abort = 1'b0;
`endif

   abr_ram_rd_stream_if #(.DATA_WIDTH(DW)) strm ();

   abr_ram_rd_stream #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .base_addr_i (base),
      .len_i       (len),
      .busy_o      (busy),
      .done_o      (done),
      .ram_re_o    (re),
      .ram_raddr_o (raddr),
      .ram_rdata_i (rdata),
`ifdef ABR_RD_STREAM_ABORT_EN
      .abort_i     (abort),
`endif
      .strm        (strm)
   );

   always #5 clk = ~clk;

   // RAM macro: registered read, contents RAM[i] = i + 0x100
   logic [DW-1:0] mem [DEPTH];
   initial for (int i = 0; i < DEPTH; i++) mem[i] = 32'h100 + i;
   always @(posedge clk) if (re) rdata <= mem[raddr];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Burst-level model: which words a burst owes, in what order, and when it must finish.
   bit            m_busy, m_done, m_ab, m_pop, stall_prev;
   int            m_base, m_len, m_issued, m_popped;
   logic [DW-1:0] stall_data;
   int            addr_log[$];
   int            pops_seen = 0;

   always @(negedge clk) begin
      if (rst) begin
         m_busy = 0; m_done = 0; stall_prev = 0;
      end else begin
         m_ab = 0;
`ifdef ABR_RD_STREAM_ABORT_EN
         m_ab = abort && m_busy;
`endif
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         if (!m_busy) chk("idle_quiet", {re, strm.valid}, 2'b00);
         if (m_ab) chk("re_in_abort", re, 1'b0);
         if (re) begin
            chk("re_owed", (m_busy && !m_done && m_issued < m_len), 1'b1);
            chk("raddr", raddr, (m_base + m_issued) % DEPTH);
            addr_log.push_back(int'(raddr));
            m_issued++;
         end
         if (stall_prev) begin
            chk("stall_valid", strm.valid, 1'b1);
            chk("stall_data", strm.data, stall_data);
         end
         m_pop = strm.valid && strm.ready && !m_ab;
         if (m_pop) begin
            chk("data", strm.data, mem[(m_base + m_popped) % DEPTH]);
            m_popped++;
            pops_seen++;
         end
         if (m_busy) chk("occupancy", (m_issued - m_popped <= 2), 1'b1);
         stall_prev = strm.valid && !strm.ready && !m_ab;
         stall_data = strm.data;
         if (m_ab || m_done) begin
            m_busy = 0; m_done = 0;
         end else if (!m_busy && start) begin
            m_busy = 1; m_base = int'(base); m_len = int'(len);
            m_issued = 0; m_popped = 0; m_done = (len == 0);
         end else if (m_busy && m_pop && m_popped == m_len) begin
            m_done = 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_burst(input int b, input int l);
      base = AW'(b); len = LW'(l); start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (busy && n < max) begin step(); n++; end
      chk("burst_end", busy, 1'b0);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_busy"}, busy, 1'b0);
      chk({nm, "_done"}, done, 1'b0);
      chk({nm, "_re"}, re, 1'b0);
      chk({nm, "_raddr"}, raddr, '0);
      chk({nm, "_valid"}, strm.valid, 1'b0);
      chk({nm, "_data"}, strm.data, '0);
   endtask

   bit [5:0] pat;

   initial begin
      strm.ready = 1'b1;
      #1 chk_all_zero("reset");
      repeat (2) step();
      rst = 1'b0;
      step();

      // Continuous read: re cycles 1-8, valid 3-10 with 0x100.., done cycle 11
      base = '0; len = LW'(8); start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         chk("t1_re", re, (k <= 8));
         chk("t1_valid", strm.valid, (k >= 3 && k <= 10));
         if (k >= 3 && k <= 10) chk("t1_data", strm.data, 32'h100 + k - 3);
         chk("t1_done", done, (k == 11));
         step();
      end

      // Wrap-around
      addr_log.delete();
      start_burst(62, 4);
      wait_idle(40);
      chk("wrap_n", addr_log.size(), 4);
      if (addr_log.size() == 4) begin
         chk("wrap_a0", addr_log[0], 62);
         chk("wrap_a1", addr_log[1], 63);
         chk("wrap_a2", addr_log[2], 0);
         chk("wrap_a3", addr_log[3], 1);
      end

      // Backpressure with a start pulse mid-burst that must be ignored
      pat = 6'b101001;  // ready per cycle, bit 0 first: 1,0,0,1,0,1
      pops_seen = 0;
      strm.ready = pat[0];
      start_burst(20, 6);
      for (int n = 1; n < 120 && busy; n++) begin
         strm.ready = pat[n % 6];
         start = (n == 4);
         base = (n == 4) ? AW'(5) : AW'(20);
         len = (n == 4) ? LW'(3) : LW'(6);
         step();
      end
      start = 1'b0; strm.ready = 1'b1;
      chk("bp_idle", busy, 1'b0);
      chk("bp_pops", pops_seen, 6);

      // Zero length
      start_burst(7, 0);
      @(negedge clk);
      chk("zl_done", done, 1'b1);
      chk("zl_re", re, 1'b0);
      chk("zl_valid", strm.valid, 1'b0);
      step();
      chk("zl_busy", busy, 1'b0);
      step();

      // Reset mid-burst after 3 words
      pops_seen = 0;
      start_burst(0, 8);
      for (int n = 0; n < 50 && pops_seen < 3; n++) step();
      chk("rst_pops", pops_seen, 3);
      rst = 1'b1;
      #1 chk_all_zero("midrst");
      step();
      rst = 1'b0;
      step();
      pops_seen = 0;
      start_burst(10, 2);
      for (int n = 0; n < 20 && !strm.valid; n++) step();
      chk("post_rst_first", strm.data, 32'h10A);
      wait_idle(40);
      chk("post_rst_pops", pops_seen, 2);

`ifdef ABR_RD_STREAM_ABORT_EN
      start_burst(0, 8);
      repeat (4) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("ab_valid", strm.valid, 1'b0);
      chk("ab_busy", busy, 1'b0);
      step();
      pops_seen = 0;
      start_burst(30, 3);
      wait_idle(40);
      chk("ab_next_pops", pops_seen, 3);
`endif

      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
